// File: rtl/mux_arbiter_pkg.sv
// Shared types for the 4-channel tri-state mux arbiter: channel indices,
// arbiter state encoding and a one-hot helper.
package mux_arbiter_pkg;

    localparam int CHANNELS = 4;

    typedef logic [1:0] channel_index_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_TURNAROUND
    } arb_state_t;

    function automatic logic [CHANNELS-1:0] one_hot(input channel_index_t idx);
        return {{(CHANNELS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux_4_arbiter_picker.sv
// Combinational round-robin search: the first requester after last_owner,
// wrapping modulo 4, so last_owner itself is considered last.
module round_robin_picker
    import mux_arbiter_pkg::*;
(
    input  logic [CHANNELS-1:0] request,
    input  channel_index_t      last_owner,
    output logic                found,
    output channel_index_t      winner
);

    channel_index_t candidate;

    always_comb begin
        found     = 1'b0;
        winner    = last_owner;
        candidate = last_owner;
        for (int offset = 1; offset <= CHANNELS; offset++) begin
            candidate = last_owner + channel_index_t'(offset);
            if (!found && request[candidate]) begin
                found  = 1'b1;
                winner = candidate;
            end
        end
    end

endmodule

// File: rtl/mux_4_arbiter.sv
// Round-robin bus-ownership controller for a 4-channel tri-state mux, with
// bounded tenures and high-Z turnaround cycles between owners.
module mux_4_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int MAX_BEATS         = 16,
    parameter int TURNAROUND_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] request,
    input  logic                bus_ready,
    output logic [1:0]          control,
    output logic                n_out_enable,
    output logic [CHANNELS-1:0] grant,
    output logic                beat
);

    localparam int BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);
    localparam logic [3:0]        LAST_TURN = 4'(TURNAROUND_CYCLES - 1);

    arb_state_t          state, state_next;
    channel_index_t      control_next;
    logic                n_out_enable_next;
    logic [CHANNELS-1:0] grant_next;
    channel_index_t      last_owner, last_owner_next;
    logic [BEAT_W-1:0]   beat_count, beat_count_next;
    logic [3:0]          turn_count, turn_count_next;

    logic                found;
    channel_index_t      winner;

    round_robin_picker u_picker (
        .request    (request),
        .last_owner (last_owner),
        .found      (found),
        .winner     (winner)
    );

    assign beat = ~n_out_enable & bus_ready;

    always_comb begin
        state_next        = state;
        control_next      = control;
        n_out_enable_next = n_out_enable;
        grant_next        = grant;
        last_owner_next   = last_owner;
        beat_count_next   = beat_count;
        turn_count_next   = turn_count;

        case (state)
            ARB_IDLE: begin
                if (found) begin
                    state_next        = ARB_GRANT;
                    control_next      = winner;
                    grant_next        = one_hot(winner);
                    n_out_enable_next = 1'b0;
                    beat_count_next   = '0;
                end
            end

            ARB_GRANT: begin
                if (beat) begin
                    beat_count_next = beat_count + BEAT_W'(1);
                end
                // A request drop is honoured only at the next edge, so the
                // owner sees one extra driven cycle after deasserting.
                if (!request[control] || (beat && beat_count == LAST_BEAT)) begin
                    state_next        = ARB_TURNAROUND;
                    n_out_enable_next = 1'b1;
                    grant_next        = '0;
                    last_owner_next   = control;
                    turn_count_next   = '0;
                end
            end

            ARB_TURNAROUND: begin
                if (turn_count == LAST_TURN) begin
                    if (found) begin
                        state_next        = ARB_GRANT;
                        control_next      = winner;
                        grant_next        = one_hot(winner);
                        n_out_enable_next = 1'b0;
                        beat_count_next   = '0;
                    end else begin
                        state_next = ARB_IDLE;
                    end
                end else begin
                    turn_count_next = turn_count + 4'd1;
                end
            end

            default: begin
                state_next        = ARB_IDLE;
                n_out_enable_next = 1'b1;
                grant_next        = '0;
            end
        endcase
    end

    // Reset drops the bus straight to high-Z and forgets the current tenure.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            control      <= 2'b00;
            n_out_enable <= 1'b1;
            grant        <= '0;
            last_owner   <= 2'd3;
            beat_count   <= '0;
            turn_count   <= '0;
        end else begin
            state        <= state_next;
            control      <= control_next;
            n_out_enable <= n_out_enable_next;
            grant        <= grant_next;
            last_owner   <= last_owner_next;
            beat_count   <= beat_count_next;
            turn_count   <= turn_count_next;
        end
    end

endmodule

// File: tb/tb_mux_4_arbiter.sv
// Scoreboard bench for mux_4_arbiter: a behavioural owner/gap model predicts
// every cycle's outputs and a separate monitor compares them against the DUT.
module tb_mux_4_arbiter;

    localparam int MAX_BEATS = 6;
    localparam int TURN      = 2;

    logic       clk;
    logic       reset;
    logic [3:0] request;
    logic       bus_ready;
    logic [1:0] control;
    logic       n_out_enable;
    logic [3:0] grant;
    logic       beat;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] control;
        logic       noe;
        logic       beat;
    } expect_t;

    expect_t sb_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cycle  = 0;

    mux_4_arbiter #(
        .MAX_BEATS         (MAX_BEATS),
        .TURNAROUND_CYCLES (TURN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .request      (request),
        .bus_ready    (bus_ready),
        .control      (control),
        .n_out_enable (n_out_enable),
        .grant        (grant),
        .beat         (beat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [3:0] actual,
                                input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
                     name, cycle, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] req, input logic rdy,
                                  input logic rst, input int n);
        request   = req;
        bus_ready = rdy;
        reset     = rst;
        repeat (n) @(negedge clk);
    endtask

    // Reference model: who owns the bus, how many words they have moved,
    // and how many high-Z cycles remain before anyone may own it again.
    initial begin : model
        int      owner;
        int      last;
        int      ctl;
        int      taken;
        int      gap;
        int      t;
        int      c;
        expect_t e;
        owner = -1; last = 3; ctl = 0; taken = 0; gap = 0;
        forever begin
            @(posedge clk);
            cycle++;
            if (reset) begin
                owner = -1; last = 3; ctl = 0; taken = 0; gap = 0;
            end else if (owner >= 0) begin
                t = taken + (bus_ready ? 1 : 0);
                if (!request[owner] || t == MAX_BEATS) begin
                    last  = owner;
                    owner = -1;
                    gap   = TURN;
                end
                taken = t;
            end else begin
                if (gap > 0) gap--;
                if (gap == 0) begin
                    for (int k = 1; k <= 4; k++) begin
                        c = (last + k) % 4;
                        if (owner < 0 && request[c]) begin
                            owner = c;
                            ctl   = c;
                            taken = 0;
                        end
                    end
                end
            end
            e.grant   = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
            e.control = 2'(ctl);
            e.noe     = (owner < 0);
            e.beat    = (owner >= 0) && bus_ready;
            sb_q.push_back(e);
        end
    end

    initial begin : monitor
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard at cycle %0d: got empty queue, expected entry", cycle);
            end else begin
                e = sb_q.pop_front();
                check_output("grant", grant, e.grant);
                check_output("control", {2'b00, control}, {2'b00, e.control});
                check_output("n_out_enable", {3'b000, n_out_enable}, {3'b000, e.noe});
                check_output("beat", {3'b000, beat}, {3'b000, e.beat});
            end
        end
    end

    initial begin : stimulus
        logic [3:0] held;
        reset     = 1'b1;
        request   = 4'b0000;
        bus_ready = 1'b0;
        held      = 4'b0000;
        @(negedge clk);

        $display("[TB] reset and first grant");
        apply_stimulus(4'b0000, 1'b0, 1'b1, 2);
        apply_stimulus(4'b0000, 1'b1, 1'b0, 2);
        apply_stimulus(4'b0100, 1'b1, 1'b0, 8);
        apply_stimulus(4'b0000, 1'b0, 1'b0, 4);

        $display("[TB] full contention");
        apply_stimulus(4'b1111, 1'b1, 1'b0, 60);

        $display("[TB] sole requester");
        apply_stimulus(4'b0000, 1'b0, 1'b1, 1);
        apply_stimulus(4'b0010, 1'b1, 1'b0, 30);
        apply_stimulus(4'b0000, 1'b1, 1'b0, 4);

        $display("[TB] stalled owner then request drop");
        apply_stimulus(4'b1000, 1'b0, 1'b0, 6);
        apply_stimulus(4'b0000, 1'b0, 1'b0, 4);

        $display("[TB] channels 0 and 2");
        apply_stimulus(4'b0101, 1'b1, 1'b0, 30);
        apply_stimulus(4'b0000, 1'b0, 1'b0, 4);

        $display("[TB] reset mid tenure");
        apply_stimulus(4'b0000, 1'b0, 1'b1, 1);
        apply_stimulus(4'b1111, 1'b1, 1'b0, 6);
        apply_stimulus(4'b1111, 1'b1, 1'b1, 1);
        apply_stimulus(4'b1111, 1'b1, 1'b0, 20);

        $display("[TB] random traffic");
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) held[b] = ~held[b];
            end
            apply_stimulus(held, $urandom_range(0, 3) != 0,
                           $urandom_range(0, 199) == 0, 1);
        end

        apply_stimulus(4'b0000, 1'b0, 1'b0, 6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_4_arbiter.md
Name: mux_4_arbiter

Overview:
Round-robin bus-ownership controller that drives the select and active-low output-enable of the 4-channel tri-state multiplexer directly upstream of it.
Four sources request the shared bus. The arbiter grants one source at a time and bounds each tenure to a maximum beat count. It inserts turnaround cycles with the mux outputs released to high-Z between owners, so two drivers never overlap on the tri bus.

Parameters:
MAX_BEATS, 16, maximum accepted beats (owner driving and bus_ready high) per tenure; legal range 1 to 256.
TURNAROUND_CYCLES, 1, high-Z cycles inserted after every tenure; legal range 1 to 15.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
request  input  4  per-source bus request; bit i = mux channel i (0 = first_channel … 3 = fourth_channel).
bus_ready  input  1  downstream consumer accepts the current bus word this cycle.
control  output  2  channel select to the 4-channel mux.
n_out_enable  output  1  active-low output enable to the mux; 1 means the bus is high-Z.
grant  output  4  one-hot current owner; all zero when the bus is not driven.
beat  output  1  = ~n_out_enable & bus_ready; marks an accepted word.

Behaviour:
- All outputs are registered except beat, which is combinational from registered n_out_enable and bus_ready.
- Reset values:
  - state = IDLE, control = 2'b00, n_out_enable = 1, grant = 4'b0000.
  - last_owner = 3, so channel 0 has first priority.
  - beat_count = 0, turn_count = 0.
- Reset mid-operation: the bus goes to high-Z on the next edge. No turnaround cycles are inserted, and the in-flight tenure is discarded.
- Priority order: search starts at (last_owner + 1) mod 4 and wraps. The sole requester can win again after its own turnaround.
- IDLE:
  - If request != 0 at an edge, go to GRANT.
  - In the same edge, load control = winner, grant = one-hot(winner), n_out_enable = 0, beat_count = 0.
  - Latency is request to grant/enable = 1 cycle.
- GRANT:
  - beat_count increments on every beat.
  - Release condition, sampled at an edge:
    - request[control] == 0, or
    - a beat occurs while beat_count == MAX_BEATS-1.
  - On release: go to TURNAROUND, set n_out_enable = 1, grant = 0, last_owner = control, turn_count = 0. control holds its value.
  - The final word is counted if bus_ready was high on the release edge.
  - Request drop is seen with 1 cycle of latency. The owner must tolerate one extra driven cycle after deasserting request.
  - Requests from other channels never preempt the current owner.
- TURNAROUND:
  - n_out_enable stays 1 for exactly TURNAROUND_CYCLES cycles.
  - On the edge ending the last turnaround cycle, arbitration runs as in IDLE. With a winner, go directly to GRANT; with no requester, go to IDLE.
  - The minimum gap between consecutive tenures is exactly TURNAROUND_CYCLES cycles.
- Invariants:
  - grant is one-hot or zero.
  - grant != 0 exactly when n_out_enable == 0.
  - When grant != 0, grant equals one-hot(control).
  - n_out_enable never goes 1 to 0 without first being 1 for at least TURNAROUND_CYCLES cycles after a tenure. Reset and the initial IDLE are exempt.
- Widths:
  - beat_count is $clog2(MAX_BEATS+1) bits.
  - turn_count is 4 bits.
  - Pointer arithmetic is 2-bit, and wrap is natural modulo-4 overflow.

Decomposition:
- Package mux_arbiter_pkg holds:
  - localparam CHANNELS = 4.
  - typedef logic [1:0] channel_index_t.
  - typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURNAROUND} arb_state_t.
- Sub-module round_robin_picker: combinational.
  - Inputs: request[3:0], last_owner.
  - Outputs: found, winner index.
  - Reused for both the IDLE and TURNAROUND-exit arbitration.

Test Plan:
- Reset, then request = 4'b0100 at cycle 2 -> at cycle 3: grant = 4'b0100, control = 2, n_out_enable = 0. The enable was 1 in every cycle before that.
- Contention, request = 4'b1111 held, MAX_BEATS = 4, bus_ready = 1 -> owners in order 0,1,2,3,0.
  - Each tenure lasts exactly 4 beats.
  - Each tenure is followed by exactly 1 cycle with n_out_enable = 1 and grant = 0.
- Sole requester channel 1 held with MAX_BEATS = 2 -> pattern grant 0010, 0010, 0000, 0010, 0010, 0000 … and control stays 1 throughout.
- Channel 3 granted, bus_ready = 0 for 5 cycles, then request[3] drops -> beat_count stays 0, no MAX_BEATS release occurs, and the bus is high-Z one cycle after the drop.
- TURNAROUND_CYCLES = 3, channels 0 and 2 requesting -> after channel 0 releases, exactly 3 high-Z cycles, then grant = 4'b0100.
- Assert reset during GRANT with beat_count = 5 -> next cycle: n_out_enable = 1, grant = 0, control = 0. After release, with request = 4'b1111 the next grant goes to channel 0.
